// File: rtl/round_key_store.sv
// Round-key store: multi-port subkey memory with
// stall-until-valid reads and a scrub sequencer.
module round_key_store #(
  parameter int KEY_W  = 128,
  parameter int DEPTH  = 15,
  parameter int N_RD   = 2,
  parameter int ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              key_size,
  input  logic                    w_en,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [KEY_W-1:0]        wkey,
  output logic                    w_err,
  input  logic                    inv_start,
  input  logic                    keep0,
  output logic                    busy,
  input  logic [N_RD-1:0]         rd_req,
  input  logic [N_RD*ADDR_W-1:0]  rd_addr,
  output logic [N_RD-1:0]         rd_ack,
  output logic [N_RD-1:0]         rd_err,
  output logic [N_RD*KEY_W-1:0]   rd_data,
  output logic [DEPTH-1:0]        valid_bits,
  output logic                    all_valid
);

  localparam int LW = ADDR_W + 1;
  localparam logic [LW-1:0] DEP = LW'(DEPTH);

  typedef enum logic {IDLE, SCRUB} state_t;

  state_t              r_state;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_ptr;
  logic [DEPTH-1:0]    r_valid;
  logic [KEY_W-1:0]    r_mem [DEPTH];
  logic                r_w_err;
  logic [N_RD-1:0]     r_ack;
  logic [N_RD-1:0]     r_err;
  logic [N_RD*KEY_W-1:0] r_data;

  logic [LW-1:0]       w_lim_raw;
  logic [LW-1:0]       w_lim;
  logic [DEPTH-1:0]    w_lim_mask;
  logic                w_wok;
  logic                w_wr0;
  logic [ADDR_W-1:0]   w_ra [N_RD];
  logic [N_RD-1:0]     w_oor;
  logic [N_RD-1:0]     w_fwd;
  logic [N_RD-1:0]     w_hit;
  logic [KEY_W-1:0]    w_rv [N_RD];

  // Entry limit never exceeds the physical depth
  always_comb begin
    unique case (key_size)
      2'd0:    w_lim_raw = LW'(11);
      2'd1:    w_lim_raw = LW'(13);
      2'd2:    w_lim_raw = LW'(15);
      default: w_lim_raw = DEP;
    endcase
  end

  assign w_lim = (w_lim_raw > DEP) ? DEP : w_lim_raw;

  always_comb begin
    w_lim_mask = '0;
    for (int k = 0; k < DEPTH; k++)
      w_lim_mask[k] = (LW'(k) < w_lim);
  end

  assign all_valid = &(r_valid | ~w_lim_mask);

  assign w_wok = w_en && !r_busy &&
                 ({1'b0, waddr} < w_lim);
  assign w_wr0 = w_wok && (waddr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_ptr   <= '0;
      r_valid <= '0;
      r_w_err <= 1'b0;
      for (int k = 0; k < DEPTH; k++)
        r_mem[k] <= '0;
    end else begin
      r_w_err <= w_en && !w_wok;
      if (w_wok) begin
        r_mem[waddr]   <= wkey;
        r_valid[waddr] <= 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (inv_start) begin
            r_state <= SCRUB;
            r_busy  <= 1'b1;
            r_ptr   <= keep0 ? ADDR_W'(1) : '0;
            r_valid <= DEPTH'(keep0 &&
                       (r_valid[0] || w_wr0));
          end
        end
        SCRUB: begin
          r_mem[r_ptr] <= '0;
          r_ptr        <= r_ptr + 1'b1;
          if (r_ptr == ADDR_W'(DEPTH-1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A same-cycle accepted write counts as valid data
  always_comb begin
    for (int i = 0; i < N_RD; i++) begin
      w_ra[i]  = rd_addr[i*ADDR_W +: ADDR_W];
      w_oor[i] = ({1'b0, w_ra[i]} >= w_lim);
      w_fwd[i] = w_wok && (waddr == w_ra[i]);
      w_hit[i] = !w_oor[i] &&
                 (w_fwd[i] || r_valid[w_ra[i]]);
      w_rv[i]  = w_fwd[i] ? wkey : r_mem[w_ra[i]];
    end
  end

  // Ack cycle is not re-evaluated: one ack per 2 cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack  <= '0;
      r_err  <= '0;
      r_data <= '0;
    end else begin
      for (int i = 0; i < N_RD; i++) begin
        r_ack[i] <= 1'b0;
        r_err[i] <= 1'b0;
        if (rd_req[i] && !r_ack[i]) begin
          if (w_oor[i]) begin
            r_ack[i] <= 1'b1;
            r_err[i] <= 1'b1;
            r_data[i*KEY_W +: KEY_W] <= '0;
          end else if (w_hit[i]) begin
            r_ack[i] <= 1'b1;
            r_data[i*KEY_W +: KEY_W] <= w_rv[i];
          end
        end
      end
    end
  end

  assign w_err      = r_w_err;
  assign busy       = r_busy;
  assign rd_ack     = r_ack;
  assign rd_err     = r_err;
  assign rd_data    = r_data;
  assign valid_bits = r_valid;

endmodule

// File: tb/tb_round_key_store.sv
// Directed bench for round_key_store: writes,
// stalled/forwarded reads, limits, scrub, reset abort.
module tb_round_key_store;

  localparam int KEY_W  = 128;
  localparam int DEPTH  = 15;
  localparam int N_RD   = 2;
  localparam int ADDR_W = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [1:0]             key_size;
  logic                   w_en;
  logic [ADDR_W-1:0]      waddr;
  logic [KEY_W-1:0]       wkey;
  logic                   w_err;
  logic                   inv_start;
  logic                   keep0;
  logic                   busy;
  logic [N_RD-1:0]        rd_req;
  logic [N_RD*ADDR_W-1:0] rd_addr;
  logic [N_RD-1:0]        rd_ack;
  logic [N_RD-1:0]        rd_err;
  logic [N_RD*KEY_W-1:0]  rd_data;
  logic [DEPTH-1:0]       valid_bits;
  logic                   all_valid;

  int n_chk = 0;
  int n_err = 0;
  int n;

  round_key_store #(
    .KEY_W(KEY_W), .DEPTH(DEPTH),
    .N_RD(N_RD), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset),
    .key_size(key_size),
    .w_en(w_en), .waddr(waddr), .wkey(wkey),
    .w_err(w_err),
    .inv_start(inv_start), .keep0(keep0),
    .busy(busy),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_err(rd_err),
    .rd_data(rd_data),
    .valid_bits(valid_bits),
    .all_valid(all_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] d0();
    return rd_data[0 +: KEY_W];
  endfunction

  function automatic logic [127:0] d1();
    return rd_data[KEY_W +: KEY_W];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; key_size = 2'd0;
    w_en = 1'b0; waddr = '0; wkey = '0;
    inv_start = 1'b0; keep0 = 1'b0;
    rd_req = '0; rd_addr = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_valid", valid_bits, 0);
    check("rst_ack", rd_ack, 0);
    check("rst_werr", w_err, 0);
    check("rst_data", rd_data[127:0], 0);
    check("rst_allv", all_valid, 0);
    reset = 1'b0;
    tick();

    // stalled read on port 1, released by write
    rd_req = 2'b10; rd_addr = {4'd7, 4'd0};
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_noack", rd_ack, 0);
    end
    w_en = 1'b1; waddr = 4'd7; wkey = 128'hA5;
    tick();
    check("stall_ack", rd_ack, 2'b10);
    check("stall_data", d1(), 128'hA5);
    w_en = 1'b0; rd_req = '0;
    tick();
    check("stall_pulse", rd_ack, 0);
    check("stall_hold", d1(), 128'hA5);

    // fill entries 0..10 with wkey=i
    for (int i = 0; i <= 10; i++) begin
      w_en = 1'b1; waddr = 4'(i); wkey = 128'(i);
      tick();
      if (i == 9) check("allv_9", all_valid, 0);
    end
    w_en = 1'b0;
    check("allv_11", all_valid, 1);

    // read addr 5, held request -> ack every 2
    rd_req = 2'b01; rd_addr = {4'd0, 4'd5};
    tick();
    check("rd5_ack", rd_ack, 2'b01);
    check("rd5_data", d0(), 5);
    check("rd5_err", rd_err, 0);
    tick();
    check("rd5_gap", rd_ack, 0);
    tick();
    check("rd5_ack2", rd_ack, 2'b01);
    rd_req = '0;
    tick();
    check("rd5_off", rd_ack, 0);
    check("rd5_hold", d0(), 5);

    // same-cycle write/read forwarding
    w_en = 1'b1; waddr = 4'd3; wkey = 128'h1234;
    rd_req = 2'b01; rd_addr = {4'd0, 4'd3};
    tick();
    check("fwd_ack", rd_ack, 2'b01);
    check("fwd_data", d0(), 128'h1234);
    w_en = 1'b0; rd_req = '0;
    tick();

    // both ports together
    rd_req = 2'b11; rd_addr = {4'd2, 4'd1};
    tick();
    check("dual_ack", rd_ack, 2'b11);
    check("dual_d0", d0(), 1);
    check("dual_d1", d1(), 2);
    rd_req = '0;
    tick();

    // out-of-limit write and read
    w_en = 1'b1; waddr = 4'd11; wkey = '1;
    tick();
    check("wr11_err", w_err, 1);
    waddr = 4'd12;
    tick();
    check("wr12_err", w_err, 1);
    check("wr12_valid", valid_bits, 15'h07FF);
    w_en = 1'b0;
    tick();
    check("werr_pulse", w_err, 0);
    rd_req = 2'b01; rd_addr = {4'd0, 4'd12};
    tick();
    check("oor_ack", rd_ack, 2'b01);
    check("oor_err", rd_err, 2'b01);
    check("oor_data", d0(), 0);
    rd_req = '0;
    tick();

    // fill to 15 entries, mark entry 0
    w_en = 1'b1; waddr = 4'd0; wkey = 128'hBEEF;
    tick();
    key_size = 2'd2;
    for (int i = 11; i <= 14; i++) begin
      waddr = 4'(i); wkey = 128'(i);
      tick();
    end
    w_en = 1'b0;
    check("full_valid", valid_bits, 15'h7FFF);
    check("full_allv", all_valid, 1);

    // scrub with keep0
    inv_start = 1'b1; keep0 = 1'b1;
    tick();
    inv_start = 1'b0;
    check("inv_valid", valid_bits, 15'h0001);
    check("inv_busy", busy, 1);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == 2) begin
        w_en = 1'b1; waddr = 4'd2; wkey = 128'h77;
      end
      if (n == 3) begin
        w_en = 1'b0;
        check("busy_werr", w_err, 1);
        rd_req = 2'b11; rd_addr = {4'd4, 4'd0};
      end
      if (n == 4) begin
        check("keep0_ack", rd_ack, 2'b01);
        check("keep0_data", d0(), 128'hBEEF);
        rd_req = 2'b10;
      end
      if (n == 5) begin
        check("scrub_stall", rd_ack, 0);
        inv_start = 1'b1; keep0 = 1'b0;
      end
      if (n == 6) inv_start = 1'b0;
      tick();
    end
    check("busy_cycles", n, 14);
    check("post_valid", valid_bits, 15'h0001);
    check("post_stall", rd_ack, 0);
    check("mem0_kept", dut.r_mem[0], 128'hBEEF);
    for (int k = 1; k < DEPTH; k++)
      check($sformatf("mem%0d_zero", k),
            dut.r_mem[k], 0);
    w_en = 1'b1; waddr = 4'd4; wkey = 128'h44;
    tick();
    check("unstall_ack", rd_ack, 2'b10);
    check("unstall_data", d1(), 128'h44);
    w_en = 1'b0; rd_req = '0;
    tick();

    // reset during scrub cycle 5
    inv_start = 1'b1; keep0 = 1'b0;
    tick();
    inv_start = 1'b0;
    check("inv2_busy", busy, 1);
    check("inv2_valid", valid_bits, 0);
    rd_req = 2'b10; rd_addr = {4'd4, 4'd0};
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check("ar_busy", busy, 0);
    check("ar_valid", valid_bits, 0);
    check("ar_ack", rd_ack, 0);
    check("ar_werr", w_err, 0);
    check("ar_d1", d1(), 0);
    check("ar_mem0", dut.r_mem[0], 0);
    tick();
    rd_req = '0; reset = 1'b0;
    tick(); tick();
    check("rel_busy", busy, 0);
    check("rel_ack", rd_ack, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/round_key_store.md
ROUND_KEY_STORE -- requirements
Module: round_key_store

Interface
REQ-001 The block SHALL have parameter KEY_W, default 128, meaning subkey width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 15, meaning number of subkey entries (11..16).
REQ-003 The block SHALL have parameter N_RD, default 2, meaning number of independent read ports.
REQ-004 The block SHALL have parameter ADDR_W, default 4, meaning entry address width; ADDR_W >= clog2(DEPTH).
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 key_size  input  2  entry limit LIM: 0 -> 11, 1 -> 13, 2 -> 15, 3 -> DEPTH; sampled every cycle.
REQ-008 w_en / waddr / wkey  input  1 / ADDR_W / KEY_W  subkey write strobe, address and data.
REQ-009 w_err  output  1  one-cycle pulse: write rejected.
REQ-010 inv_start / keep0  input  1 / 1  start invalidation; keep0=1 preserves entry 0.
REQ-011 busy  output  1  scrub sequence in progress.
REQ-012 rd_req  input  N_RD  per-port read request; held high until acked.
REQ-013 rd_addr  input  N_RD*ADDR_W  per-port read address; port i at bits [i*ADDR_W +: ADDR_W].
REQ-014 rd_ack / rd_err  output  N_RD / N_RD  per-port one-cycle completion pulse and error flag.
REQ-015 rd_data  output  N_RD*KEY_W  per-port registered read data; port i at bits [i*KEY_W +: KEY_W].
REQ-016 valid_bits  output  DEPTH  per-entry valid flags.
REQ-017 all_valid  output  1  high when entries 0..LIM-1 are all valid.

Function
REQ-018 A write with waddr < LIM, while not busy, SHALL store wkey and set valid_bits[waddr] at the edge.
REQ-019 A write with waddr >= LIM, or while busy=1, SHALL leave mem and valid_bits unchanged and pulse w_err the next cycle.
REQ-020 Read port i with rd_req[i]=1 and a valid address SHALL pulse rd_ack[i] one cycle later with rd_data = mem[rd_addr] and rd_err=0.
REQ-021 A read of an invalid entry SHALL stall with no ack until the entry becomes valid, then ack one cycle after the validating write.
REQ-022 A write and a read to the same address in the same cycle SHALL return wkey on the ack one cycle later (write forwarding).
REQ-023 A read with rd_addr >= LIM SHALL ack one cycle later with rd_err=1 and rd_data=0.
REQ-024 rd_data[i] SHALL hold its last value between acks; ports SHALL operate independently, with no port-to-port priority.
REQ-025 After an ack, a still-high rd_req SHALL start a new read in that cycle, giving a maximum throughput of one ack every 2 cycles per port.
REQ-026 FSM states SHALL be IDLE and SCRUB.
REQ-027 IDLE -> SCRUB on inv_start: at that edge clear valid_bits (except bit 0 if keep0), set busy, and load scrub pointer = keep0 ? 1 : 0.
REQ-028 In SCRUB, each cycle SHALL zero mem[pointer] and increment the pointer; after entry DEPTH-1 the FSM SHALL return to IDLE and busy SHALL fall, for DEPTH or DEPTH-1 busy cycles.
REQ-029 inv_start while busy SHALL be ignored.
REQ-030 Reads stalled across invalidation SHALL keep stalling; reads of entry 0 with keep0=1 SHALL still succeed during SCRUB.
REQ-031 all_valid SHALL be combinational from valid_bits and key_size.

Reset
REQ-032 On reset: all mem entries 0, valid_bits 0, FSM IDLE, busy 0, rd_ack/rd_err/w_err 0, rd_data 0, all pending reads dropped.
REQ-033 Reset asserted mid-SCRUB or mid-stall SHALL abort immediately; after release, no ack SHALL issue for requests made before reset unless rd_req is re-presented.

Verification
REQ-034 key_size=0; write addr 0..10 with wkey=i; read port 0 addr 5 -> ack after 1 cycle, data 5; all_valid=1 after the 11th write.
REQ-035 Port 1 reads addr 7 while invalid; write addr 7 = 0xA5 three cycles later -> rd_ack[1] one cycle after the write, data 0xA5.
REQ-036 Same-cycle write addr 3 = 0x1234 and port 0 read addr 3 -> ack next cycle, data 0x1234.
REQ-037 key_size=0; write addr 12 -> w_err pulse, valid_bits unchanged; read addr 12 -> ack with rd_err=1, data 0.
REQ-038 All 15 entries valid, inv_start with keep0=1 -> valid_bits=15'h0001 next cycle, busy for 14 cycles, mem[1..14]=0, mem[0] intact; write during busy -> w_err.
REQ-039 Assert reset during SCRUB cycle 5 -> all outputs 0 immediately; busy stays 0 after release.
